// File: rtl/counters_pkg.sv
// -----------------------------------------------------------------------------
// counters_pkg
// Shared definitions for the T flip-flop counter family.
//   mod_legal()    : elaboration-time range check, 2 <= MOD <= 2**WIDTH
//   mod_max()      : terminal count MOD-1
//   clamp_to_max() : limit a load value to the terminal count
//   t_sel_e        : which toggle vector drives the T flip-flop chain
// -----------------------------------------------------------------------------
package counters_pkg;

  localparam int MIN_MOD   = 2;
  localparam int MAX_WIDTH = 31;

  typedef enum logic [1:0] {
    T_HOLD = 2'd0,  // no toggles, count holds
    T_LOAD = 2'd1,  // toggle towards the clamped load value
    T_WRAP = 2'd2,  // 0 -> MOD-1 reload
    T_DEC  = 2'd3   // borrow-ripple decrement
  } t_sel_e;

  function automatic bit mod_legal(input int width, input longint mod);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (mod >= longint'(MIN_MOD)) && (mod <= (longint'(1) << width));
  endfunction

  function automatic int unsigned mod_max(input int unsigned mod);
    return mod - 32'd1;
  endfunction

  function automatic int unsigned clamp_to_max(input int unsigned value,
                                               input int unsigned max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/t_down_counter_mod_if.sv
// -----------------------------------------------------------------------------
// t_down_counter_mod_if
// Control/status bundle of one down-counter stage.
//   en     : count enable                (master -> slave)
//   load   : synchronous load strobe     (master -> slave)
//   d      : load value, WIDTH bits      (master -> slave)
//   q      : current count               (slave -> master)
//   borrow : combinational cascade enable (slave -> master)
//   wrap   : registered wrap pulse       (slave -> master)
// -----------------------------------------------------------------------------
interface t_down_counter_mod_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             borrow;
  logic             wrap;

  modport master (output en, load, d, input q, borrow, wrap);
  modport slave  (input en, load, d, output q, borrow, wrap);
endinterface

// File: rtl/t_flip_flop.sv
// -----------------------------------------------------------------------------
// t_flip_flop
// Single toggle flip-flop: q inverts on a rising clk edge while t is high.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high, clears q
//   t     : toggle enable
//   q     : stored bit
// -----------------------------------------------------------------------------
module t_flip_flop (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)  q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/t_down_counter_mod.sv
// -----------------------------------------------------------------------------
// t_down_counter_mod
// Modulo-MOD down counter whose every state bit is a T flip-flop. Decrement,
// 0 -> MOD-1 reload and parallel load are all expressed as toggle vectors.
// Parameters: WIDTH (count bits), MOD (modulus, 2..2**WIDTH).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high, clears count and wrap
//   bus   : slave side of t_down_counter_mod_if (en/load/d in,
//           q/borrow/wrap out); bus WIDTH must equal WIDTH here
// Priority at each edge: reset > load > en.
// -----------------------------------------------------------------------------
module t_down_counter_mod
  import counters_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  t_down_counter_mod_if.slave   bus
);

  if (!mod_legal(WIDTH, longint'(MOD))) begin : g_bad_mod
    $error("t_down_counter_mod: MOD=%0d outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(mod_max(MOD));

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_dec_t;
  logic [WIDTH-1:0] w_d_clamped;
  logic             w_q_zero;
  logic             w_wrap_now;
  t_sel_e           w_sel;
  logic             r_wrap;

  assign w_q_zero    = (w_q == '0);
  // Counting out of zero: this is both the reload condition and the borrow
  // handed to the next stage, so a load in the same cycle suppresses both.
  assign w_wrap_now  = bus.en & ~bus.load & w_q_zero;
  assign w_d_clamped = WIDTH'(clamp_to_max(32'(bus.d), 32'(MAX_COUNT)));

  // Borrow ripple: bit i toggles when every lower bit is zero.
  always_comb begin : p_dec_toggle
    logic low_bits_zero;
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    low_bits_zero = 1'b1;
    w_dec_t       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_dec_t[i]    = bus.en & low_bits_zero;
      low_bits_zero = low_bits_zero & ~w_q[i];
    end
  end

  always_comb begin : p_sel
    w_sel = T_HOLD;
    if (bus.load)        w_sel = T_LOAD;
    else if (w_wrap_now) w_sel = T_WRAP;
    else if (bus.en)     w_sel = T_DEC;
  end

  // A toggle vector of (current ^ target) lands the chain on target.
  always_comb begin : p_toggle
    w_t = '0;
    case (w_sel)
      T_LOAD:  w_t = w_q ^ w_d_clamped;
      T_WRAP:  w_t = w_q ^ MAX_COUNT;
      T_DEC:   w_t = w_dec_t;
      default: w_t = '0;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
    t_flip_flop u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (w_t[gi]),
      .q     (w_q[gi])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wrap <= 1'b0;
    else       r_wrap <= w_wrap_now;
  end

  assign bus.q      = w_q;
  assign bus.borrow = w_wrap_now;
  assign bus.wrap   = r_wrap;

endmodule

// File: tb/tb_t_down_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_t_down_counter_mod
// Directed bench for t_down_counter_mod: MOD=8 and MOD=6 three-bit stages,
// plus a two-stage MOD=4 cascade (stage B enabled by stage A borrow).
// -----------------------------------------------------------------------------
module tb_t_down_counter_mod;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  t_down_counter_mod_if #(.WIDTH(3)) bus8 ();
  t_down_counter_mod_if #(.WIDTH(3)) bus6 ();
  t_down_counter_mod_if #(.WIDTH(2)) bus_a ();
  t_down_counter_mod_if #(.WIDTH(2)) bus_b ();

  t_down_counter_mod #(.WIDTH(3), .MOD(8)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
  t_down_counter_mod #(.WIDTH(3), .MOD(6)) u_dut6  (.clk(clk), .reset(reset), .bus(bus6));
  t_down_counter_mod #(.WIDTH(2), .MOD(4)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  t_down_counter_mod #(.WIDTH(2), .MOD(4)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.en = bus_a.borrow;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e8, e6, ec;
    reset = 1'b1;
    bus8.en = 1'b0;  bus8.load = 1'b0;  bus8.d = '0;
    bus6.en = 1'b0;  bus6.load = 1'b0;  bus6.d = '0;
    bus_a.en = 1'b0; bus_a.load = 1'b0; bus_a.d = '0;
    bus_b.load = 1'b0; bus_b.d = '0;

    // Reset state
    #12;
    check("rst_q8", bus8.q, 0);
    check("rst_wrap8", bus8.wrap, 0);
    check("rst_borrow8_idle", bus8.borrow, 0);
    check("rst_q6", bus6.q, 0);
    bus8.en = 1'b1;
    #1;
    check("rst_borrow8_en", bus8.borrow, 1);
    reset   = 1'b0;
    bus6.en = 1'b1;

    // Free-running count, MOD=8 and MOD=6 side by side
    for (int k = 1; k <= 10; k++) begin
      tick();
      e8 = (8 - (k % 8)) % 8;
      e6 = (6 - (k % 6)) % 6;
      check($sformatf("cnt8_q_%0d", k), bus8.q, e8);
      check($sformatf("cnt8_wrap_%0d", k), bus8.wrap, (k % 8 == 1) ? 1 : 0);
      check($sformatf("cnt8_borrow_%0d", k), bus8.borrow, (e8 == 0) ? 1 : 0);
      check($sformatf("cnt6_q_%0d", k), bus6.q, e6);
      check($sformatf("cnt6_wrap_%0d", k), bus6.wrap, (k % 6 == 1) ? 1 : 0);
      check($sformatf("cnt6_range_%0d", k), (bus6.q < 3'd6) ? 1 : 0, 1);
    end

    // Load overrides en; load above MOD-1 clamps
    bus8.load = 1'b1; bus8.d = 3'd3;
    bus6.load = 1'b1; bus6.d = 3'd7;
    #1;
    check("load8_borrow", bus8.borrow, 0);
    tick();
    check("load8_q", bus8.q, 3);
    check("load8_wrap", bus8.wrap, 0);
    check("load6_clamp_q", bus6.q, 5);
    check("load6_wrap", bus6.wrap, 0);

    // Idle hold
    bus8.en = 1'b0; bus8.d = 3'd4;
    bus6.en = 1'b0; bus6.d = 3'd0;
    tick();
    check("load8_q4", bus8.q, 4);
    check("load6_q0", bus6.q, 0);
    bus8.load = 1'b0;
    bus6.load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("idle8_q_%0d", k), bus8.q, 4);
      check($sformatf("idle8_borrow_%0d", k), bus8.borrow, 0);
      check($sformatf("idle8_wrap_%0d", k), bus8.wrap, 0);
    end
    check("idle6_q0", bus6.q, 0);
    check("idle6_borrow", bus6.borrow, 0);
    check("idle6_wrap", bus6.wrap, 0);

    // Borrow at q=0 follows en and is masked by load; load at q=0 gives no wrap
    bus6.en = 1'b1;
    #1;
    check("zero6_borrow_en", bus6.borrow, 1);
    bus6.load = 1'b1; bus6.d = 3'd0;
    #1;
    check("zero6_borrow_load", bus6.borrow, 0);
    tick();
    check("zero6_load_q", bus6.q, 0);
    check("zero6_load_wrap", bus6.wrap, 0);
    bus6.load = 1'b0;
    bus6.en   = 1'b0;

    // Asynchronous reset mid-cycle
    bus8.load = 1'b1; bus8.d = 3'd5;
    tick();
    check("pre_rst_q8", bus8.q, 5);
    bus8.load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_q8", bus8.q, 0);
    check("async_rst_wrap8", bus8.wrap, 0);
    #2;
    reset   = 1'b0;
    bus8.en = 1'b1;
    tick();
    check("post_rst_q8", bus8.q, 7);
    check("post_rst_wrap8", bus8.wrap, 1);
    tick();
    check("post_rst2_q8", bus8.q, 6);
    check("post_rst2_wrap8", bus8.wrap, 0);
    bus8.en = 1'b0;

    // Two-stage cascade, 16 combined states
    check("casc_start", {bus_b.q, bus_a.q}, 0);
    bus_a.en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      ec = (16 - k) % 16;
      check($sformatf("casc_q_%0d", k), {bus_b.q, bus_a.q}, ec);
      check($sformatf("casc_wrap_a_%0d", k), bus_a.wrap, (k % 4 == 1) ? 1 : 0);
      check($sformatf("casc_wrap_b_%0d", k), bus_b.wrap, (k == 1) ? 1 : 0);
      check($sformatf("casc_borrow_a_%0d", k), bus_a.borrow, (ec % 4 == 0) ? 1 : 0);
      check($sformatf("casc_borrow_b_%0d", k), bus_b.borrow, (ec == 0) ? 1 : 0);
    end
    bus_a.en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_down_counter_mod.md
Name: t_down_counter_mod

Overview:
- Synchronous modulo-MOD down counter built from T flip-flops; the count-down counterpart of the team's 3-bit T-FF up counter.
- Used for countdown timers and cascaded prescalers; a combinational borrow output drives the enable of the next stage.
- Every state bit is a T flip-flop. All next-state behaviour (decrement, wrap reload, parallel load) is expressed only as per-bit toggle enables.

Parameters:
- WIDTH, 3, count width in bits.
- MOD, 8, modulus. Legal range: 2 ≤ MOD ≤ 2**WIDTH. Elaboration error outside that range.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1. Asynchronous, active-high; clears all state.
- en, input, 1, count enable: decrement by one per clk edge while high.
- load, input, 1, synchronous parallel load strobe.
- d, input, WIDTH, load value.
- q, output, WIDTH, current count.
- borrow, output, 1. Combinational: en & (q == 0) & ~load. Cascade enable for the next stage.
- wrap, output, 1. Registered one-cycle pulse, high in the cycle after a 0 → MOD-1 wrap.

Behaviour:
- Reset (asynchronous, any time): q = 0, wrap = 0. borrow follows en and q (= en & ~load while q = 0).
- Priority at each clk edge: reset > load > en. Idle when neither load nor en is high: q holds, wrap = 0.
- Load:
  - q ← d if d ≤ MOD-1; else q ← MOD-1 (clamp).
  - Load overrides en in the same cycle; no wrap pulse is generated.
- Count (en = 1, load = 0):
  - q ≠ 0: q ← q - 1.
  - q = 0: q ← MOD-1, and wrap = 1 on the following cycle.
- Toggle-enable rules (bit i of the T-FF chain):
  - Decrement, q ≠ 0: t[i] = en & (q[i-1:0] == 0), with t[0] = en. This is the borrow ripple, the mirror of the up counter's AND chain.
  - Wrap: t = q ^ (MOD-1) = MOD-1, since q = 0.
  - Load: t = q ^ d_clamped.
  - t-vector select priority: load, then wrap condition, then decrement.
- Latency: q updates on the clk edge where load/en is sampled. wrap lags the wrap edge by one cycle. borrow has zero latency (combinational).
- Non-power-of-two MOD (e.g. 6, WIDTH 3): states MOD..2**WIDTH-1 are never reached by counting. If such a state is entered, en decrements normally back into range.
- Cascade: when stage B has en = stage A borrow, B decrements exactly once per A wrap.
- Reset mid-count: q = 0 immediately, asynchronously. The first en edge after reset release gives q = MOD-1 plus a wrap pulse.
- No X propagation: every state element is reset.

Decomposition:
- Shared package (counters_pkg):
  - constant function clamp/limit helper for MOD-1 at WIDTH bits;
  - localparam checks for the MOD range.
- Sub-module: reuse the existing t_flip_flop (clk, reset, t, q) unchanged, instantiated WIDTH times in a generate loop.
- Toggle-vector logic and wrap register stay in t_down_counter_mod.

Test Plan:
- Reset, then en = 1 for 10 cycles, MOD=8: q = 0,7,6,5,4,3,2,1,0,7. wrap is high exactly in the cycle after each 0→7 edge. borrow is high while q = 0.
- MOD=6, WIDTH=3: sequence 0,5,4,3,2,1,0,5. q never reaches 6 or 7. wrap pulses twice.
- Load d = 3 with en = 1 in the same cycle → q = 3, no decrement, no wrap. Load d = 7 with MOD=6 → q = 5 (clamp).
- en low for 4 cycles at q = 4 → q holds at 4, borrow = 0, wrap = 0. Idle at q = 0 with en = 0 → borrow = 0.
- Assert reset asynchronously mid-cycle at q = 5 → q = 0 before the next clk edge. Deassert, en = 1 → q = 7 (MOD=8), then wrap = 1.
- Cascade two instances (MOD=4 each), stage B en = stage A borrow, 16 enabled cycles: combined count goes down through all 16 states. B decrements exactly when A goes 0→3.
